// File: rtl/rv32i_types.sv
// RV32I shared types.
// Provides the base opcode enumeration, the register index type, and the
// canonical NOP instruction word (ADDI x0,x0,0) used by the fetch/decode path.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef logic [4:0] rv32i_reg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage : rv32i_types

// File: rtl/rv32i_insn_decode.sv
// RV32I instruction field decoder (purely combinational).
// Ports:
//   insn_i               instruction word
//   funct3_o, funct7_o   function fields
//   opcode_o             base opcode
//   rs1_o, rs2_o, rd_o   register indices
//   i/s/b/u/j_imm_o      sign-extended immediates
module rv32i_insn_decode
    import rv32i_types::*;
(
    input  logic [31:0] insn_i,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output rv32i_opcode opcode_o,
    output rv32i_reg    rs1_o,
    output rv32i_reg    rs2_o,
    output rv32i_reg    rd_o,
    output logic [31:0] i_imm_o,
    output logic [31:0] s_imm_o,
    output logic [31:0] b_imm_o,
    output logic [31:0] u_imm_o,
    output logic [31:0] j_imm_o
);

    always_comb begin
        funct3_o = insn_i[14:12];
        funct7_o = insn_i[31:25];
        opcode_o = rv32i_opcode'(insn_i[6:0]);
        rs1_o    = insn_i[19:15];
        rs2_o    = insn_i[24:20];
        rd_o     = insn_i[11:7];
        i_imm_o  = {{21{insn_i[31]}}, insn_i[30:20]};
        s_imm_o  = {{21{insn_i[31]}}, insn_i[30:25], insn_i[11:7]};
        b_imm_o  = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
        u_imm_o  = {insn_i[31:12], 12'h000};
        j_imm_o  = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
    end

endmodule : rv32i_insn_decode

// File: rtl/ifid_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry circular buffer of {pc, insn} between fetch
// and decode with valid/ready handshakes on both sides. The head entry is
// presented pre-decoded; while empty, decode sees NOP_INSN at pc 0.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop all entries (redirect)
//   enq_valid/enq_ready  fetch-side handshake, enq_pc/enq_insn payload
//   deq_valid/deq_ready  decode-side handshake
//   deq_pc, deq_pc_plus4, deq_insn   head entry (or NOP when empty)
//   funct3..j_imm        decoded fields of the head word
//   count                occupancy
module ifid_fetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  NOP_INSN = rv32i_types::NOP_INSN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_insn,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc_plus4,
    output logic [XLEN-1:0]          deq_insn,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output rv32i_opcode              opcode,
    output rv32i_reg                 rs1,
    output rv32i_reg                 rs2,
    output rv32i_reg                 rd,
    output logic [31:0]              i_imm,
    output logic [31:0]              s_imm,
    output logic [31:0]              b_imm,
    output logic [31:0]              u_imm,
    output logic [31:0]              j_imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] insn_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic enq_fire;
    logic deq_fire;

    assign empty     = (count_q == '0);
    assign enq_ready = (count_q != CW'(DEPTH));
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;
    assign count     = count_q;

    // Flush overrides any same-cycle handshake; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PW'(1);
            if (deq_fire) head_d = head_q + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_q[tail_q]   <= enq_pc;
            insn_q[tail_q] <= enq_insn;
        end
    end

    always_comb begin
        deq_insn     = empty ? NOP_INSN : insn_q[head_q];
        deq_pc       = empty ? '0 : pc_q[head_q];
        deq_pc_plus4 = empty ? '0 : deq_pc + XLEN'(4);
    end

    rv32i_insn_decode u_decode (
        .insn_i   (deq_insn[31:0]),
        .funct3_o (funct3),
        .funct7_o (funct7),
        .opcode_o (opcode),
        .rs1_o    (rs1),
        .rs2_o    (rs2),
        .rd_o     (rd),
        .i_imm_o  (i_imm),
        .s_imm_o  (s_imm),
        .b_imm_o  (b_imm),
        .u_imm_o  (u_imm),
        .j_imm_o  (j_imm)
    );

endmodule : ifid_fetch_queue

// File: tb/tb_ifid_fetch_queue.sv
module tb_ifid_fetch_queue;
    import rv32i_types::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, flush, enq_valid, deq_ready;
    logic [31:0] enq_pc, enq_insn;
    logic enq_ready, deq_valid;
    logic [31:0] deq_pc, deq_pc_plus4, deq_insn;
    logic [2:0] funct3;
    logic [6:0] funct7;
    rv32i_opcode opcode;
    rv32i_reg rs1, rs2, rd;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    ifid_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP_INSN(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_insn(enq_insn),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_pc_plus4(deq_pc_plus4), .deq_insn(deq_insn),
        .funct3(funct3), .funct7(funct7), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm),
        .count(count)
    );

    // Advance one clock and apply the queue rules to the reference model.
    task automatic cycle();
        bit ef, df, clr;
        ent_t e;
        ef  = enq_valid && (mq.size() < DEPTH);
        df  = deq_ready && (mq.size() > 0);
        clr = rst || flush;
        e.pc = enq_pc;
        e.insn = enq_insn;
        @(posedge clk);
        #1;
        if (clr) mq.delete();
        else begin
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; enq_valid = 0; deq_ready = 0; enq_pc = '0; enq_insn = '0;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: w[6:0] = 7'b0010011;
            8: w[6:0] = 7'b0110011;
            default: w[6:0] = 7'b1110011;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        cycle();
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (deq_valid !== 1'b0) $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); else n_pass++;
        n_checks++; if (deq_insn !== 32'h13) $display("FAIL reset_insn got=%h exp=00000013", deq_insn); else n_pass++;
        n_checks++; if (deq_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", deq_pc); else n_pass++;
        n_checks++; if (rd !== 5'd0 || i_imm !== 32'h0 || opcode !== op_imm)
            $display("FAIL reset_decode got rd=%0d i_imm=%h op=%h exp rd=0 i_imm=0 op=13", rd, i_imm, 7'(opcode)); else n_pass++;
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1; enq_pc = 32'h60 + 32'(4 * i); enq_insn = rand_insn();
            cycle();
        end
        n_checks++; if (count !== 3'd4) $display("FAIL full_count got=%0d exp=4", count); else n_pass++;
        n_checks++; if (enq_ready !== 1'b0) $display("FAIL full_enq_ready got=%b exp=0", enq_ready); else n_pass++;
        enq_pc = 32'h70; enq_insn = rand_insn();
        cycle();
        n_checks++; if (count !== 3'd4) $display("FAIL fifth_enq_count got=%0d exp=4", count); else n_pass++;
        enq_valid = 0; deq_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (deq_pc !== 32'h60 + 32'(4 * i))
                $display("FAIL drain_pc[%0d] got=%h exp=%h", i, deq_pc, 32'h60 + 32'(4 * i)); else n_pass++;
            n_checks++; if (deq_pc_plus4 !== 32'h64 + 32'(4 * i))
                $display("FAIL drain_pc4[%0d] got=%h exp=%h", i, deq_pc_plus4, 32'h64 + 32'(4 * i)); else n_pass++;
            cycle();
        end
        n_checks++; if (deq_valid !== 1'b0) $display("FAIL drained_valid got=%b exp=0", deq_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_single();
        idle_inputs();
        enq_valid = 1; enq_pc = 32'h80; enq_insn = 32'h0050_0093;
        #1;
        n_checks++; if (deq_valid !== 1'b0) $display("FAIL single_same_cycle_valid got=%b exp=0", deq_valid); else n_pass++;
        cycle();
        enq_valid = 0;
        n_checks++; if (deq_valid !== 1'b1) $display("FAIL single_next_valid got=%b exp=1", deq_valid); else n_pass++;
        n_checks++; if (opcode !== op_imm || rd !== 5'd1 || i_imm !== 32'd5 || deq_pc !== 32'h80)
            $display("FAIL single_decode got op=%h rd=%0d i_imm=%h pc=%h exp op=13 rd=1 i_imm=5 pc=80",
                     7'(opcode), rd, i_imm, deq_pc); else n_pass++;
        deq_ready = 1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_wrap();
        idle_inputs();
        enq_valid = 1;
        for (int i = 0; i < 2; i++) begin
            enq_pc = 32'h1000 + 32'(4 * i); enq_insn = rand_insn(); cycle();
        end
        deq_ready = 1;
        for (int i = 0; i < 8; i++) begin
            enq_pc = 32'h2000 + 32'(4 * i); enq_insn = rand_insn();
            n_checks++; if (deq_pc !== mq[0].pc || deq_insn !== mq[0].insn)
                $display("FAIL wrap_head[%0d] got pc=%h insn=%h exp pc=%h insn=%h", i, deq_pc, deq_insn, mq[0].pc, mq[0].insn); else n_pass++;
            cycle();
            n_checks++; if (count !== 3'd2) $display("FAIL wrap_count[%0d] got=%0d exp=2", i, count); else n_pass++;
        end
        enq_valid = 0;
        cycle(); cycle();
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        enq_valid = 1;
        for (int i = 0; i < 3; i++) begin
            enq_pc = 32'h300 + 32'(4 * i); enq_insn = rand_insn(); cycle();
        end
        deq_ready = 1; flush = 1; enq_pc = 32'hDEAD_0000; enq_insn = 32'h0000_0033;
        #1;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL flush_enq_ready got=%b exp=1", enq_ready); else n_pass++;
        cycle();
        flush = 0; enq_valid = 0; deq_ready = 0;
        n_checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || deq_insn !== 32'h13)
            $display("FAIL flush_empty got count=%0d valid=%b insn=%h exp 0 0 00000013", count, deq_valid, deq_insn); else n_pass++;
        enq_valid = 1; enq_pc = 32'h400; enq_insn = rand_insn();
        cycle();
        enq_valid = 0;
        n_checks++; if (deq_pc !== 32'h400) $display("FAIL flush_dropped got=%h exp=00000400", deq_pc); else n_pass++;
        deq_ready = 1; cycle();
        idle_inputs();
    endtask

    task automatic test_pc_wrap_and_reset();
        idle_inputs();
        enq_valid = 1; enq_pc = 32'hFFFF_FFFC; enq_insn = rand_insn();
        cycle();
        enq_valid = 0;
        n_checks++; if (deq_pc_plus4 !== 32'h0) $display("FAIL pc4_wrap got=%h exp=00000000", deq_pc_plus4); else n_pass++;
        enq_valid = 1; enq_pc = 32'h500; enq_insn = rand_insn();
        cycle();
        n_checks++; if (count !== 3'd2) $display("FAIL pre_reset_count got=%0d exp=2", count); else n_pass++;
        rst = 1; flush = 1; enq_pc = 32'h504;
        cycle();
        rst = 0; flush = 0; enq_valid = 0;
        n_checks++; if (count !== 3'd0 || enq_ready !== 1'b1 || deq_pc !== 32'h0)
            $display("FAIL midfill_reset got count=%0d ready=%b pc=%h exp 0 1 0", count, enq_ready, deq_pc); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] w, e_pc, e_pc4, e_i, e_s, e_b, e_u, e_j;
        int sw;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            enq_valid = ($urandom_range(0, 3) != 0);
            deq_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            enq_pc    = $urandom() & 32'hFFFF_FFFC;
            enq_insn  = rand_insn();
            #1;
            w     = (mq.size() > 0) ? mq[0].insn : 32'h0000_0013;
            e_pc  = (mq.size() > 0) ? mq[0].pc : 32'h0;
            e_pc4 = (mq.size() > 0) ? mq[0].pc + 32'd4 : 32'h0;
            sw    = signed'(w);
            e_i   = 32'(sw >>> 20);
            e_s   = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
            e_b   = 32'((sw >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            e_u   = w & 32'hFFFF_F000;
            e_j   = 32'((sw >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            n_checks++; if (count !== 3'(mq.size()) || enq_ready !== (mq.size() < DEPTH) || deq_valid !== (mq.size() > 0))
                $display("FAIL rand_occ[%0d] got count=%0d ready=%b valid=%b exp count=%0d", c, count, enq_ready, deq_valid, mq.size()); else n_pass++;
            n_checks++; if (deq_insn !== w || deq_pc !== e_pc || deq_pc_plus4 !== e_pc4)
                $display("FAIL rand_head[%0d] got insn=%h pc=%h pc4=%h exp insn=%h pc=%h pc4=%h", c, deq_insn, deq_pc, deq_pc_plus4, w, e_pc, e_pc4); else n_pass++;
            n_checks++; if (7'(opcode) !== w[6:0] || funct3 !== w[14:12] || funct7 !== w[31:25] ||
                            rs1 !== w[19:15] || rs2 !== w[24:20] || rd !== w[11:7])
                $display("FAIL rand_fields[%0d] got op=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d for insn=%h", c, 7'(opcode), funct3, funct7, rs1, rs2, rd, w); else n_pass++;
            n_checks++; if (i_imm !== e_i || s_imm !== e_s || b_imm !== e_b || u_imm !== e_u || j_imm !== e_j)
                $display("FAIL rand_imm[%0d] got i=%h s=%h b=%h u=%h j=%h exp i=%h s=%h b=%h u=%h j=%h", c, i_imm, s_imm, b_imm, u_imm, j_imm, e_i, e_s, e_b, e_u, e_j); else n_pass++;
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_single();
        test_wrap();
        test_flush();
        test_pc_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ifid_fetch_queue
